// File: rtl/tmds_symbol_sequencer.sv
// Per-pixel TMDS lane symbol scheduler: control / preamble / guard / video, fixed 11-cycle latency.
// Define TMDS_HDMI_GUARD_EN to insert the HDMI video preamble and guard band (otherwise plain DVI).
module tmds_symbol_sequencer #(
  parameter int CTRL_MIN = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        link_en,
  input  logic        de,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [29:0] tmds_in,
  output logic [9:0]  par_data0,
  output logic [9:0]  par_data1,
  output logic [9:0]  par_data2,
  output logic        video_active,
  output logic        short_ctrl
);

  localparam logic [9:0] CTRL00  = 10'b1101010100;
  localparam logic [9:0] CTRL01  = 10'b0010101011;
  localparam logic [9:0] CTRL10  = 10'b0101010100;
  localparam logic [9:0] CTRL11  = 10'b1010101011;
  localparam logic [9:0] GUARD_A = 10'b1011001100;
  localparam logic [9:0] GUARD_B = 10'b0100110011;

  typedef enum logic [1:0] {ST_CTRL, ST_PREAMBLE, ST_GUARD, ST_VIDEO} state_t;

  state_t      state;
  logic [2:0]  phase;
  logic [32:0] dly [10];
  logic        ge;
  logic        arm;
  logic        short_next;
  logic        d_ge;
  logic [1:0]  d_hv;
  logic [29:0] d_px;

  assign ge   = de & link_en;
  assign d_ge = dly[9][32];
  assign d_hv = {dly[9][30], dly[9][31]};
  assign d_px = dly[9][29:0];

  // Lookahead line: stage 0 holds the previous input cycle, stage 9 feeds the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 10; i++) dly[i] <= '0;
    end else begin
      dly[0] <= {ge, hsync, vsync, tmds_in};
      for (int i = 1; i < 10; i++) dly[i] <= dly[i-1];
    end
  end

`ifdef TMDS_HDMI_GUARD_EN
  localparam logic [3:0] CTRL_MIN_W = 4'(CTRL_MIN);

  logic [3:0] run_cnt;
  logic       rise;
  logic       long_run;

  always_ff @(posedge clk) begin
    if (rst || ge) run_cnt <= '0;
    else if (run_cnt != 4'd15) run_cnt <= run_cnt + 4'd1;
  end

  // The rise is seen at the input, ten cycles ahead of the data reaching the output register,
  // which is exactly the room needed for 8 preamble + 2 guard symbols.
  assign rise       = ge & ~dly[0][32];
  assign long_run   = (run_cnt >= CTRL_MIN_W);
  assign arm        = rise & long_run;
  assign short_next = rise & ~long_run;
`else
  assign arm        = 1'b0;
  assign short_next = 1'b0;
`endif

  function automatic logic [9:0] ctrl_sym(input logic [1:0] idx);
    case (idx)
      2'b00:   ctrl_sym = CTRL00;
      2'b01:   ctrl_sym = CTRL01;
      2'b10:   ctrl_sym = CTRL10;
      default: ctrl_sym = CTRL11;
    endcase
  endfunction

  // Packs {video_active, lane2, lane1, lane0} for the state being entered.
  function automatic logic [30:0] emit(input state_t s, input logic [1:0] hv, input logic [29:0] px);
    case (s)
      ST_PREAMBLE: emit = {1'b0, CTRL00, CTRL01, ctrl_sym(hv)};
      ST_GUARD:    emit = {1'b0, GUARD_A, GUARD_B, GUARD_A};
      ST_VIDEO:    emit = {1'b1, px};
      default:     emit = {1'b0, CTRL00, CTRL00, ctrl_sym(hv)};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_CTRL;
      phase        <= '0;
      par_data0    <= CTRL00;
      par_data1    <= CTRL00;
      par_data2    <= CTRL00;
      video_active <= 1'b0;
      short_ctrl   <= 1'b0;
    end else begin
      short_ctrl <= short_next;
      case (state)
        ST_CTRL: begin
          if (arm) begin
            state <= ST_PREAMBLE;
            phase <= '0;
            {video_active, par_data2, par_data1, par_data0} <= emit(ST_PREAMBLE, d_hv, d_px);
          end else if (d_ge) begin
            state <= ST_VIDEO;
            {video_active, par_data2, par_data1, par_data0} <= emit(ST_VIDEO, d_hv, d_px);
          end else begin
            {video_active, par_data2, par_data1, par_data0} <= emit(ST_CTRL, d_hv, d_px);
          end
        end
        ST_PREAMBLE: begin
          if (phase == 3'd7) begin
            state <= ST_GUARD;
            phase <= '0;
            {video_active, par_data2, par_data1, par_data0} <= emit(ST_GUARD, d_hv, d_px);
          end else begin
            phase <= phase + 3'd1;
            {video_active, par_data2, par_data1, par_data0} <= emit(ST_PREAMBLE, d_hv, d_px);
          end
        end
        ST_GUARD: begin
          // A link drop during the lead-in leaves delayed ge low here; fall back to control.
          if (phase == 3'd1) begin
            phase <= '0;
            state <= d_ge ? ST_VIDEO : ST_CTRL;
            {video_active, par_data2, par_data1, par_data0} <=
              emit(d_ge ? ST_VIDEO : ST_CTRL, d_hv, d_px);
          end else begin
            phase <= phase + 3'd1;
            {video_active, par_data2, par_data1, par_data0} <= emit(ST_GUARD, d_hv, d_px);
          end
        end
        default: begin
          state <= d_ge ? ST_VIDEO : ST_CTRL;
          {video_active, par_data2, par_data1, par_data0} <=
            emit(d_ge ? ST_VIDEO : ST_CTRL, d_hv, d_px);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tmds_symbol_sequencer.sv
// Self-checking bench for tmds_symbol_sequencer: a history-based reference model fills a
// scoreboard queue per driven cycle, and each scenario task adds its own spot checks.
module tb_tmds_symbol_sequencer;

  localparam logic [9:0] C00 = 10'b1101010100;
  localparam logic [9:0] C01 = 10'b0010101011;
  localparam logic [9:0] C10 = 10'b0101010100;
  localparam logic [9:0] C11 = 10'b1010101011;
  localparam logic [9:0] GA  = 10'b1011001100;
  localparam logic [9:0] GB  = 10'b0100110011;
  localparam int N = 2048;
`ifdef TMDS_HDMI_GUARD_EN
  localparam logic GUARD = 1'b1;
`else
  localparam logic GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, link_en, de, hsync, vsync;
  logic [29:0] tmds_in;
  logic [9:0]  par_data0, par_data1, par_data2;
  logic        video_active, short_ctrl;

  tmds_symbol_sequencer #(.CTRL_MIN(12)) dut (
    .clk(clk), .rst(rst), .link_en(link_en), .de(de), .hsync(hsync), .vsync(vsync),
    .tmds_in(tmds_in), .par_data0(par_data0), .par_data1(par_data1), .par_data2(par_data2),
    .video_active(video_active), .short_ctrl(short_ctrl)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0] par;
    logic        va;
    logic        sc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        got_e;
  bit          ge_h [N];
  logic [1:0]  vh_h [N];
  logic [29:0] px_h [N];
  int          lastrst_h [N];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  function automatic logic [9:0] ctrl_sym(input logic [1:0] idx);
    case (idx)
      2'b00:   return C00;
      2'b01:   return C01;
      2'b10:   return C10;
      default: return C11;
    endcase
  endfunction

`ifdef TMDS_HDMI_GUARD_EN
  function automatic bit rise_at(input int r, input int lr);
    return ge_h[r] && ((r - 1 <= lr) || !ge_h[r-1]);
  endfunction

  // Armed when at least 12 post-reset blank input cycles precede the rise.
  function automatic bit armed_at(input int r, input int lr);
    if (r - 12 <= lr) return 1'b0;
    if (!rise_at(r, lr)) return 1'b0;
    for (int j = r - 12; j < r; j++) if (ge_h[j]) return 1'b0;
    return 1'b1;
  endfunction
`endif

  // Expected outputs for output cycle c, derived from the input history only.
  function automatic exp_t model(input int c);
    exp_t        e;
    int          lr, d;
    bit          dge;
    logic [1:0]  dhv;
    logic [29:0] dpx;
    lr    = lastrst_h[c-1];
    e.sc  = 1'b0;
    e.va  = 1'b0;
    e.par = {C00, C00, C00};
    if (lr == c - 1) return e;
    d   = c - 11;
    dge = (d > lr) ? ge_h[d] : 1'b0;
    dhv = (d > lr) ? vh_h[d] : 2'b00;
    dpx = (d > lr) ? px_h[d] : '0;
    if (dge) begin
      e.va  = 1'b1;
      e.par = dpx;
    end else begin
      e.par = {C00, C00, ctrl_sym(dhv)};
    end
`ifdef TMDS_HDMI_GUARD_EN
    for (int r = c - 10; r <= c - 1; r++) begin
      if (r > lr && armed_at(r, lr)) begin
        e.va  = 1'b0;
        e.par = (c - r <= 8) ? {C00, C01, ctrl_sym(dhv)} : {GA, GB, GA};
      end
    end
    e.sc = rise_at(c - 1, lr) && !armed_at(c - 1, lr);
`endif
    return e;
  endfunction

  task automatic applyStimulus(input logic r, input logic l, input logic d, input logic h,
                               input logic v, input logic [29:0] px);
    @(negedge clk);
    rst = r; link_en = l; de = d; hsync = h; vsync = v; tmds_in = px;
    ge_h[cyc]      = d & l;
    vh_h[cyc]      = {v, h};
    px_h[cyc]      = px;
    lastrst_h[cyc] = r ? cyc : ((cyc == 0) ? -1000 : lastrst_h[cyc-1]);
    exp_q.push_back(model(cyc + 1));
    cyc++;
  endtask

  // Scoreboard: the entry pushed at the previous falling edge describes the outputs now visible.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      got_e = exp_q.pop_front();
      checks += 3;
      if ({par_data2, par_data1, par_data0} !== got_e.par) begin
        errors++;
        $display("[TB] FAIL sb_lanes t=%0t got %h expected %h", $time,
                 {par_data2, par_data1, par_data0}, got_e.par);
      end
      if (video_active !== got_e.va) begin
        errors++;
        $display("[TB] FAIL sb_video_active t=%0t got %b expected %b", $time, video_active, got_e.va);
      end
      if (short_ctrl !== got_e.sc) begin
        errors++;
        $display("[TB] FAIL sb_short_ctrl t=%0t got %b expected %b", $time, short_ctrl, got_e.sc);
      end
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 30'($urandom));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 30'($urandom));
      @(posedge clk); #2;
      checks++;
      if ({par_data2, par_data1, par_data0} !== {C00, C00, C00} || video_active !== 1'b0 ||
          short_ctrl !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_state got %h/%b/%b expected %h/0/0",
                 {par_data2, par_data1, par_data0}, video_active, short_ctrl, {C00, C00, C00});
      end
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 30'($urandom));
    @(posedge clk); #2;
    checks++;
    if (short_ctrl !== GUARD) begin
      errors++;
      $display("[TB] FAIL reset_short_ctrl got %b expected %b", short_ctrl, GUARD);
    end
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 30'($urandom));
  endtask

  task automatic test_ctrl_map();
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 30'($urandom));
      if (i == 10) begin
        @(posedge clk); #2;
        checks++;
        if (par_data0 !== C01 || par_data1 !== C00 || par_data2 !== C00 || video_active !== 1'b0) begin
          errors++;
          $display("[TB] FAIL ctrl_map got %b %b %b va=%b expected %b %b %b va=0",
                   par_data0, par_data1, par_data2, video_active, C01, C00, C00);
        end
      end
    end
  endtask

  task automatic test_long_blank();
    logic [29:0] pix;
    int t, k;
    pix = {10'h3FF, 10'h0AA, 10'h155};
    t = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) t = cyc;
      if (i >= 20 && i < 24) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, pix);
      else applyStimulus(1'b0, 1'b1, 1'b0, 1'($urandom), 1'b0, 30'($urandom));
      if (i >= 20) begin
        @(posedge clk); #2;
        k = cyc - t;
`ifdef TMDS_HDMI_GUARD_EN
        if (k >= 1 && k <= 8) begin
          checks++;
          if (par_data1 !== C01 || par_data2 !== C00 || video_active !== 1'b0) begin
            errors++;
            $display("[TB] FAIL long_preamble k=%0d got %b %b va=%b expected %b %b va=0",
                     k, par_data1, par_data2, video_active, C01, C00);
          end
        end
        if (k == 9 || k == 10) begin
          checks++;
          if ({par_data2, par_data1, par_data0} !== {GA, GB, GA}) begin
            errors++;
            $display("[TB] FAIL long_guard k=%0d got %h expected %h",
                     k, {par_data2, par_data1, par_data0}, {GA, GB, GA});
          end
        end
`else
        if (k >= 1 && k <= 10) begin
          checks++;
          if (par_data1 !== C00 || par_data2 !== C00 || video_active !== 1'b0 || short_ctrl !== 1'b0) begin
            errors++;
            $display("[TB] FAIL dvi_no_preamble k=%0d got %b %b va=%b sc=%b expected %b %b va=0 sc=0",
                     k, par_data1, par_data2, video_active, short_ctrl, C00, C00);
          end
        end
`endif
        if (k >= 11 && k <= 14) begin
          checks++;
          if ({par_data2, par_data1, par_data0} !== pix || video_active !== 1'b1) begin
            errors++;
            $display("[TB] FAIL long_video k=%0d got %h va=%b expected %h va=1",
                     k, {par_data2, par_data1, par_data0}, video_active, pix);
          end
        end
        if (k == 15) begin
          checks++;
          if (video_active !== 1'b0) begin
            errors++;
            $display("[TB] FAIL long_end k=%0d video_active got %b expected 0", k, video_active);
          end
        end
      end
    end
  endtask

  task automatic test_short_blank();
    logic [29:0] pix;
    int t, k;
    pix = 30'($urandom);
    t = 0;
    for (int i = 0; i < 27; i++) begin
      if (i == 9) t = cyc;
      if (i < 4) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 30'($urandom));
      else if (i < 9) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 30'($urandom));
      else if (i < 13) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, (i == 9) ? pix : 30'($urandom));
      else applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      if (i >= 9) begin
        @(posedge clk); #2;
        k = cyc - t;
        if (k == 1) begin
          checks++;
          if (short_ctrl !== GUARD) begin
            errors++;
            $display("[TB] FAIL short_pulse got %b expected %b", short_ctrl, GUARD);
          end
        end
        if (k == 11) begin
          checks++;
          if ({par_data2, par_data1, par_data0} !== pix || video_active !== 1'b1) begin
            errors++;
            $display("[TB] FAIL short_resume got %h va=%b expected %h va=1",
                     {par_data2, par_data1, par_data0}, video_active, pix);
          end
        end
      end
    end
  endtask

  task automatic test_link_drop();
    int kc, k;
    kc = 0;
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 22; i++) begin
      if (i == 3) kc = cyc;
      if (i == 3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 30'($urandom));
      else if (i < 8) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 30'($urandom));
      else applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
      if (i >= 3) begin
        @(posedge clk); #2;
        k = cyc - kc;
        if (k == 11) begin
          checks++;
          if (par_data0 !== C10 || video_active !== 1'b0) begin
            errors++;
            $display("[TB] FAIL link_drop_ctrl got %b va=%b expected %b va=0",
                     par_data0, video_active, C10);
          end
        end
        if (k == 12) begin
          checks++;
          if (video_active !== 1'b1) begin
            errors++;
            $display("[TB] FAIL link_drop_resume video_active got %b expected 1", video_active);
          end
        end
      end
    end
  endtask

  task automatic test_random();
    logic d, h, v;
    d = 1'b0; h = 1'b0; v = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0) d = ~d;
      if ($urandom_range(0, 15) == 0) h = ~h;
      if ($urandom_range(0, 31) == 0) v = ~v;
      applyStimulus(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 19) != 0),
                    d, h, v, 30'($urandom));
    end
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    rst = 1'b1; link_en = 1'b1; de = 1'b0; hsync = 1'b0; vsync = 1'b0; tmds_in = '0;
    test_reset();
    test_ctrl_map();
    test_long_blank();
    test_short_blank();
    test_link_drop();
    test_random();
    @(posedge clk); #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d entries left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tmds_symbol_sequencer.md
# tmds_symbol_sequencer

Per-pixel symbol scheduler for the three TMDS lanes that sits between the TMDS encoders and the three 10:1 serializers, one `par_data` word per lane per pixel clock. It chooses, for every pixel cycle and lane, between encoded video, a control-period symbol carrying HSYNC/VSYNC, and, when compiled in, the HDMI video preamble and guard band. It runs a fixed-depth lookahead delay line so that the preamble and guard band can be placed before active video.

## Interface
- `CTRL_MIN`, default 12: minimum control-period length, in input cycles, for a preamble and guard band to be inserted.
- `clk` input 1: pixel clock, the same clock the serializers' parallel data is launched from.
- `rst` input 1: synchronous, active-high reset.
- `link_en` input 1: link enable. When low, the input `de` is treated as 0.
- `de` input 1: data enable, aligned with `tmds_in`.
- `hsync` input 1: horizontal sync.
- `vsync` input 1: vertical sync.
- `tmds_in` input 30: encoded video symbols; [9:0] lane0, [19:10] lane1, [29:20] lane2.
- `par_data0`, `par_data1`, `par_data2` output 10 each: symbols to the lane 0/1/2 serializers.
- `video_active` output 1: high while the outputs carry video symbols.
- `short_ctrl` output 1: one-cycle pulse when a video period starts after a control run shorter than `CTRL_MIN`.

## Operation
- **Gated DE:** `ge = de & link_en`.
- **Delay line:** a 10-stage delay line carries {ge, hsync, vsync, tmds_in}. An output register follows it.
- **Control symbols,** indexed by {C1,C0}:
  - 00 → 1101010100
  - 01 → 0010101011
  - 10 → 0101010100
  - 11 → 1010101011
- **Control period lane mapping:**
  - Lane0 uses {vsync, hsync} (delayed).
  - Lane1 and lane2 use {0,0}.
- **Run counter:** counts consecutive `ge == 0` input cycles and saturates at 15.
  - It is cleared in the cycle `ge` is high.
  - A rising `ge` with count ≥ `CTRL_MIN` arms insertion.
  - A rising `ge` with count < `CTRL_MIN` does not arm insertion and pulses `short_ctrl` in the next cycle.
- **Output FSM states:** CTRL, PREAMBLE, GUARD, VIDEO.
  - CTRL → PREAMBLE: insertion armed (macro builds only).
  - PREAMBLE (8 cycles) → GUARD.
  - GUARD (2 cycles) → VIDEO.
  - CTRL → VIDEO: delayed `ge` = 1 without arming.
  - VIDEO → CTRL: delayed `ge` = 0.
  - A 3-bit phase counter times PREAMBLE and GUARD.
- **PREAMBLE symbols:**
  - Lane0: control symbol for delayed {vsync, hsync}.
  - Lane1: {0,1} → 0010101011.
  - Lane2: {0,0} → 1101010100.
- **GUARD symbols:**
  - Lane0: 1011001100.
  - Lane1: 0100110011.
  - Lane2: 1011001100.
- **VIDEO symbols:** delayed `tmds_in` lanes, passed unchanged. `video_active` = 1.
- **`link_en` drop mid-video:** `ge` falls, the delayed stream truncates the video period 11 cycles later, and the FSM goes to CTRL.
- **`link_en` drop during PREAMBLE or GUARD:** the sequence completes.
  - If delayed `ge` is 0 when GUARD ends, the FSM goes to CTRL and no video symbol is emitted.
- **Reset:**
  - All delay stages, the run counter and the phase counter are cleared.
  - The FSM enters CTRL.
  - `par_data0/1/2` = 1101010100.
  - `video_active` = 0.
  - `short_ctrl` = 0.
  - The run counter restarts at 0, so a `de` rise within 12 cycles after reset gets no preamble and pulses `short_ctrl`.

## Timing
- Fixed latency of 11 cycles from `tmds_in`/`de`/`hsync`/`vsync` to the `par_data*`/`video_active` outputs, in both builds.
- First video pixel accepted at input cycle T appears at output cycle T+11.
- With insertion armed:
  - Preamble occupies output cycles T+1..T+8.
  - Guard band occupies output cycles T+9..T+10.
  - The preamble and guard replace the last 10 control symbols of the run.
- `short_ctrl` is asserted in cycle T+1.
- All outputs are registered.

## Configuration
- `TMDS_HDMI_GUARD_EN`:
  - **Defined:** preamble and guard band are inserted as described (HDMI video period).
  - **Undefined:** the FSM never enters PREAMBLE or GUARD, giving pure DVI with only CTRL and VIDEO. Latency stays 11 cycles. `short_ctrl` stays 0.

## Test plan
- **Reset:** assert `rst` for 3 cycles mid-frame → all lanes output 1101010100 and `video_active` = 0 on the next cycle.
- **Control mapping:** `de` = 0, hsync = 1, vsync = 0 → 11 cycles later lane0 = 0010101011 and lanes 1/2 = 1101010100.
- **Guard build, long blank:** 20 blank cycles, then `de` high for 4 cycles with `tmds_in` lanes = 0x155/0x0AA/0x3FF →
  - T+1..T+8: lane1 = 0010101011.
  - T+9..T+10: guard band symbols.
  - T+11..T+14: 0x155/0x0AA/0x3FF with `video_active` = 1.
  - T+15: CTRL.
- **Guard build, short blank:** 5-cycle blank between video periods → no preamble or guard; `short_ctrl` pulses at T+1; video resumes at T+11.
- **DVI build:** the same long-blank stimulus produces no preamble or guard symbols; video appears at T+11.
- **`link_en` drop:** deassert `link_en` for 1 cycle mid-video at input cycle K → output cycle K+11 is a control symbol and `video_active` = 0, followed by a new video period.
